// File: rtl/bist_resp_analyzer_if.sv
// Read-beat stream and result bus between the BIST controller and the
// response analyzer. The controller (master) drives the read beats and
// start pulse. The analyzer (slave) returns status and results.
interface bist_resp_analyzer_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              rd_valid;
  logic              rd_last;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [2:0]        exp_sel;

  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_cnt;
  logic [7:0]        fail_mask;
  logic [ADDR_W-1:0] first_fail_addr;
  logic [7:0]        first_fail_data;
  logic [7:0]        first_fail_exp;

  modport master (
    output start, rd_valid, rd_last, rd_addr, rd_data, exp_sel,
    input  busy, done, pass, err_cnt, fail_mask,
           first_fail_addr, first_fail_data, first_fail_exp
  );

  modport slave (
    input  start, rd_valid, rd_last, rd_addr, rd_data, exp_sel,
    output busy, done, pass, err_cnt, fail_mask,
           first_fail_addr, first_fail_data, first_fail_exp
  );
endinterface

// File: rtl/bist_resp_analyzer.sv
// SRAM BIST response analyzer. Each read beat is compared against the
// expected pattern for its selector. The block accumulates a saturating
// error count, a sticky failing-bit mask and a first-failure record.
// Two-stage pipeline: stage 1 registers the beat, stage 2 compares it
// and updates the results.
module bist_resp_analyzer #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bist_resp_analyzer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q;
  logic              busy_q, done_q;

  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [7:0]        s1_data_q;
  logic [7:0]        s1_exp_q;

  logic [CNT_W-1:0]  err_cnt_q;
  logic [7:0]        fail_mask_q;
  logic              captured_q;
  logic [ADDR_W-1:0] ff_addr_q;
  logic [7:0]        ff_data_q;
  logic [7:0]        ff_exp_q;

  logic [7:0]        exp_pat;
  logic [7:0]        diff;
  logic              take_start;
  logic              accept;

  // A start is honoured only when no test is running. Beats are accepted only in RUN.
  assign take_start = bus.start && (state_q == IDLE || state_q == DONE);
  assign accept     = bus.rd_valid && (state_q == RUN);
  assign diff       = s1_data_q ^ s1_exp_q;

  // Expected-pattern decode for the beat's selector.
  always_comb begin
    // NOTE: a default assignment before the case keeps this purely combinational; a missing path would infer a latch.
    exp_pat = 8'h00;
    case (bus.exp_sel)
      3'b000:  exp_pat = 8'hAA;
      3'b001:  exp_pat = 8'h55;
      3'b010:  exp_pat = 8'hF0;
      3'b011:  exp_pat = 8'h0F;
      3'b100:  exp_pat = 8'h00;
      3'b101:  exp_pat = 8'hFF;
      3'b110:  exp_pat = 8'h00;
      3'b111:  exp_pat = 8'hFF;
      default: exp_pat = 8'h00;
    endcase
  end

  // Control FSM with registered busy/done. DRAIN waits until the compare stage is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.rd_valid && bus.rd_last) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!s1_valid_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture the accepted beat and its expected pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_exp_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= bus.rd_addr;
        s1_data_q <= bus.rd_data;
        s1_exp_q  <= exp_pat;
      end
    end
  end

  // Stage 2: compare and accumulate results. A start clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q   <= '0;
      fail_mask_q <= '0;
      captured_q  <= 1'b0;
      ff_addr_q   <= '0;
      ff_data_q   <= '0;
      ff_exp_q    <= '0;
    end else if (take_start) begin
      err_cnt_q   <= '0;
      fail_mask_q <= '0;
      captured_q  <= 1'b0;
      ff_addr_q   <= '0;
      ff_data_q   <= '0;
      ff_exp_q    <= '0;
    end else if (s1_valid_q && (diff != 8'h00)) begin
      if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
      fail_mask_q <= fail_mask_q | diff;
      if (!captured_q) begin
        captured_q <= 1'b1;
        ff_addr_q  <= s1_addr_q;
        ff_data_q  <= s1_data_q;
        ff_exp_q   <= s1_exp_q;
      end
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = done_q && (err_cnt_q == '0);
  assign bus.err_cnt         = err_cnt_q;
  assign bus.fail_mask       = fail_mask_q;
  assign bus.first_fail_addr = ff_addr_q;
  assign bus.first_fail_data = ff_data_q;
  assign bus.first_fail_exp  = ff_exp_q;

endmodule

// File: tb/tb_bist_resp_analyzer.sv
// Testbench for bist_resp_analyzer. Two instances share one stimulus
// stream: one with a 16-bit error counter and one with a 4-bit counter,
// so saturation is observed alongside the normal results. Expected
// results come from a beat-list model and are queued when a test is
// issued. A monitor pops and compares them when done rises.
module tb_bist_resp_analyzer;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bist_resp_analyzer_if #(.ADDR_W(AW), .CNT_W(16)) bus16 ();
  bist_resp_analyzer_if #(.ADDR_W(AW), .CNT_W(4))  bus4 ();

  assign bus4.start    = bus16.start;
  assign bus4.rd_valid = bus16.rd_valid;
  assign bus4.rd_last  = bus16.rd_last;
  assign bus4.rd_addr  = bus16.rd_addr;
  assign bus4.rd_data  = bus16.rd_data;
  assign bus4.exp_sel  = bus16.exp_sel;

  bist_resp_analyzer #(.ADDR_W(AW), .CNT_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16.slave)
  );
  bist_resp_analyzer #(.ADDR_W(AW), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [2:0]    sel;
  } beat_t;

  typedef struct {
    int unsigned   errs;
    logic [7:0]    mask;
    logic [AW-1:0] ffa;
    logic [7:0]    ffd;
    logic [7:0]    ffe;
    int unsigned   done_cyc;
  } exp_t;

  localparam logic [7:0] PAT [8] = '{8'hAA, 8'h55, 8'hF0, 8'h0F, 8'h00, 8'hFF, 8'h00, 8'hFF};

  int   checks = 0;
  int   failures = 0;
  int unsigned cyc = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic done_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the beat list, count mismatches, OR the differences and keep the first failure.
  function automatic exp_t model(input beat_t b[$]);
    exp_t e;
    bit   found;
    logic [7:0] x;
    e.errs = 0; e.mask = 8'h00; e.ffa = '0; e.ffd = 8'h00; e.ffe = 8'h00; e.done_cyc = 0;
    found = 1'b0;
    foreach (b[i]) begin
      x = b[i].data ^ PAT[b[i].sel];
      if (x != 8'h00) begin
        e.errs++;
        e.mask |= x;
        if (!found) begin
          found = 1'b1;
          e.ffa = b[i].addr; e.ffd = b[i].data; e.ffe = PAT[b[i].sel];
        end
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] sat(input int unsigned v, input int unsigned max);
    return (v > max) ? max : v;
  endfunction

  function automatic beat_t mk(input int unsigned a, input logic [7:0] d, input logic [2:0] s);
    beat_t b;
    b.addr = a[AW-1:0]; b.data = d; b.sel = s;
    return b;
  endfunction

  // Monitor: compare queued expectations whenever a test completes.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_d = 1'b0;
    end else begin
      if (bus16.done && !done_d) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("done_latency",    cyc, mon_e.done_cyc);
          check("err_cnt16",       bus16.err_cnt, sat(mon_e.errs, 65535));
          check("err_cnt4_sat",    bus4.err_cnt, sat(mon_e.errs, 15));
          check("fail_mask",       bus16.fail_mask, mon_e.mask);
          check("first_fail_addr", bus16.first_fail_addr, mon_e.ffa);
          check("first_fail_data", bus16.first_fail_data, mon_e.ffd);
          check("first_fail_exp",  bus16.first_fail_exp, mon_e.ffe);
          check("pass",            bus16.pass, (mon_e.errs == 0) ? 1 : 0);
          check("busy_at_done",    bus16.busy, 0);
        end
      end
      done_d = bus16.done;
    end
  end

  task automatic idle_inputs();
    bus16.start = 1'b0; bus16.rd_valid = 1'b0; bus16.rd_last = 1'b0;
    bus16.rd_addr = '0; bus16.rd_data = 8'h00; bus16.exp_sel = 3'b000;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    bus16.busy, 0);
    check({tag, "_done"},    bus16.done, 0);
    check({tag, "_pass"},    bus16.pass, 0);
    check({tag, "_err"},     bus16.err_cnt, 0);
    check({tag, "_err4"},    bus4.err_cnt, 0);
    check({tag, "_mask"},    bus16.fail_mask, 0);
    check({tag, "_ffa"},     bus16.first_fail_addr, 0);
    check({tag, "_ffd"},     bus16.first_fail_data, 0);
    check({tag, "_ffe"},     bus16.first_fail_exp, 0);
  endtask

  // Start a test, stream its beats (with random gaps) and wait for the monitor.
  // With noisy=1: a dropped beat rides along with start, stray start/rd_last appear
  // in gaps, and beats are driven while in DONE afterwards.
  task automatic run_test(input beat_t b[$], input bit noisy);
    exp_t e;
    int   t;
    e = model(b);
    @(posedge clk); #1;
    bus16.start = 1'b1;
    bus16.rd_valid = noisy; bus16.rd_last = noisy;
    bus16.rd_addr = 10'h3FF; bus16.rd_data = 8'h12; bus16.exp_sel = 3'b101;
    @(posedge clk); #1;
    idle_inputs();
    check("start_clr_err",  bus16.err_cnt, 0);
    check("start_clr_mask", bus16.fail_mask, 0);
    check("start_clr_ffa",  bus16.first_fail_addr, 0);
    check("start_busy",     bus16.busy, 1);
    check("start_done",     bus16.done, 0);
    foreach (b[i]) begin
      repeat ($urandom_range(0, 2)) begin
        bus16.rd_valid = 1'b0;
        bus16.start    = noisy && ($urandom_range(0, 1) == 1);
        bus16.rd_last  = $urandom_range(0, 1) == 1;
        bus16.rd_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      bus16.rd_valid = 1'b1;
      bus16.start    = noisy && ($urandom_range(0, 1) == 1);
      bus16.rd_last  = (i == b.size() - 1);
      bus16.rd_addr  = b[i].addr;
      bus16.rd_data  = b[i].data;
      bus16.exp_sel  = b[i].sel;
      if (i == b.size() - 1) begin
        e.done_cyc = cyc + 3;
        sb_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      @(posedge clk); t++;
    end
    check("done_timeout", sb_q.size(), 0);
    if (noisy) begin
      #1;
      repeat (3) begin
        bus16.rd_valid = 1'b1; bus16.rd_last = 1'b1;
        bus16.exp_sel = 3'b000; bus16.rd_data = 8'h00;
        @(posedge clk); #1;
      end
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("done_beats_ignored_err",  bus16.err_cnt, sat(e.errs, 65535));
      check("done_beats_ignored_mask", bus16.fail_mask, e.mask);
      check("done_held",               bus16.done, 1);
    end
  endtask

  initial begin
    beat_t b[$];
    int    n;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // 4 matching beats of pattern AA.
    b.delete();
    for (int i = 0; i < 4; i++) b.push_back(mk(i, 8'hAA, 3'b000));
    run_test(b, 1'b0);

    // addr 0..7 against FF with two failing beats.
    b.delete();
    for (int i = 0; i < 8; i++)
      b.push_back(mk(i, (i == 3) ? 8'hF7 : (i == 6) ? 8'h7F : 8'hFF, 3'b101));
    run_test(b, 1'b1);

    // Selector sweep: matching, then inverted data.
    b.delete();
    for (int i = 0; i < 8; i++) b.push_back(mk(i, PAT[i], 3'(i)));
    run_test(b, 1'b0);
    b.delete();
    for (int i = 0; i < 8; i++) b.push_back(mk(i + 16, ~PAT[i], 3'(i)));
    run_test(b, 1'b1);

    // 20 mismatching beats: the 4-bit counter must stop at 15.
    b.delete();
    for (int i = 0; i < 20; i++) begin
      logic [2:0] s;
      s = 3'($urandom_range(0, 7));
      b.push_back(mk($urandom_range(0, 1023), PAT[s] ^ 8'($urandom_range(1, 255)), s));
    end
    run_test(b, 1'b1);

    // Randomized tests with roughly half the beats failing.
    for (int k = 0; k < 6; k++) begin
      b.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        logic [2:0] s;
        s = 3'($urandom_range(0, 7));
        b.push_back(mk($urandom_range(0, 1023),
                       ($urandom_range(0, 1) == 1) ? PAT[s] : 8'($urandom), s));
      end
      run_test(b, k[0]);
    end

    // Reset during RUN after two failing beats, then a clean 2-beat run.
    @(posedge clk); #1;
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus16.rd_valid = 1'b1; bus16.rd_addr = AW'(i + 5);
      bus16.exp_sel = 3'b010; bus16.rd_data = 8'h00;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
    check("pre_reset_err", bus16.err_cnt, 2);
    check("pre_reset_busy", bus16.busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    b.delete();
    b.push_back(mk(0, 8'h55, 3'b001));
    b.push_back(mk(1, 8'h0F, 3'b011));
    run_test(b, 1'b0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bist_resp_analyzer.md
Name: bist_resp_analyzer

Overview:
- Read-side checker for the SRAM BIST datapath: compares SRAM read-back data against the expected 8-bit pattern for the active pattern selector.
- Accumulates an error count, a sticky failing-bit mask, and a first-failure record.
- Sits after the SRAM read port, in parallel with the address counter and pattern decoder; the BIST controller streams read beats into it and samples pass/fail at end of test.

Parameters:
ADDR_W, 10, width of the read address (matches the address counter length)
CNT_W, 16, width of the error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse: clear results and begin a test
rd_valid  input  1  read beat valid (rd_addr, rd_data, exp_sel, rd_last qualified)
rd_last  input  1  marks final beat of the test
rd_addr  input  ADDR_W  address of the read beat
rd_data  input  8  data read from SRAM
exp_sel  input  3  pattern selector for this beat (same encoding as the BIST pattern decoder)
busy  output  1  high in RUN or DRAIN
done  output  1  high in DONE (level, held)
pass  output  1  done && err_cnt==0
err_cnt  output  CNT_W  mismatching beats, saturating
fail_mask  output  8  OR of (rd_data XOR expected) over all beats
first_fail_addr  output  ADDR_W  address of first mismatching beat
first_fail_data  output  8  rd_data of first mismatching beat
first_fail_exp  output  8  expected value of first mismatching beat

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; pipeline valid flag 0; first-fail captured flag 0.
- Expected pattern per exp_sel: 000->AA, 001->55, 010->F0, 011->0F, 100->00, 101->FF, 110->00, 111->FF. No Z outputs; all codes defined.
- FSM: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN, clearing err_cnt, fail_mask, first_fail_* and the captured flag.
  - RUN: each edge with rd_valid=1 accepts one beat. An accepted beat with rd_last=1 -> DRAIN.
  - DRAIN: one cycle to flush the compare stage -> DONE.
  - DONE: holds results. start -> RUN with the same clear as from IDLE.
- Pipeline, two stages:
  - Stage 1 registers addr, data, expected pattern and valid.
  - Stage 2 computes the XOR and updates the results.
  - A beat accepted at edge N is reflected in err_cnt/fail_mask after edge N+1.
  - Last beat accepted at edge N: done=1 and busy=0 after edge N+2.
- Mismatch means (data XOR expected) != 0.
  - On mismatch: err_cnt += 1, saturating at 2^CNT_W-1 (no wrap).
  - fail_mask |= data XOR expected.
  - If no failure has been captured yet, load first_fail_addr/data/exp and set the captured flag. Later failures never overwrite.
- rd_valid is ignored in IDLE, DRAIN and DONE. start is ignored in RUN and DRAIN.
- rd_valid may drop mid-test; gaps are legal, and there is no timeout.
- start and rd_valid in the same IDLE/DONE cycle: start is taken, the beat is dropped.
- rd_last with rd_valid=0 is ignored.
- rst_n asserted mid-test: immediate return to IDLE with all outputs 0; any in-flight beat is discarded.
- pass is combinational from done and err_cnt. It is 0 whenever done=0.

Test Plan:
- Reset then start; 4 beats, exp_sel=000, rd_data=AA each, last on beat 4 -> done=1 two cycles after beat 4, pass=1, err_cnt=0, fail_mask=00.
- Start; beats addr 0..7, exp_sel=101, data=FF except addr 3 data=F7 and addr 6 data=7F -> err_cnt=2, fail_mask=88, first_fail_addr=3, first_fail_data=F7, first_fail_exp=FF, pass=0.
- Sweep all 8 exp_sel codes with matching data, then each with data inverted -> 0 errors on the first pass; 8 errors with fail_mask=FF on the inverted pass; codes 110/111 expect 00/FF.
- CNT_W=4; 20 mismatching beats -> err_cnt saturates at 15, does not wrap.
- Assert rst_n low during RUN after 2 failing beats -> all outputs 0 immediately, state IDLE. A following start and clean 2-beat run -> pass=1.
- In DONE with err_cnt=2, pulse start -> results cleared next cycle, busy=1. start pulses during RUN and rd_valid beats in DONE have no effect.
